str_lane_deserializer: RTL
==========================

Name: str_lane_deserializer

Overview:
- Serial-to-parallel receiver. Collects a 1-bit valid/ready stream into N-bit words.
- Bit k of each word is captured by lane k. Lanes are built from a labeled generate loop of per-lane capture cells.
- Sits at the receive end of the lane-serialized link. It is the consumer of the per-lane `data[i]` drivers.
- Completed words are presented on a valid/ready output. There is one word of output buffering plus the in-progress shift word.

Parameters:
- N, 4, word width = number of lanes; legal range 2..32.
- CNT_W, $clog2(N+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous flush of the partial word; the output register is untouched.
- s_valid  input  1  serial bit valid.
- s_ready  output  1  serial bit accepted when s_valid && s_ready.
- s_bit  input  1  serial data bit, LSB (lane 0) first.
- m_valid  output  1  completed word available.
- m_ready  input  1  downstream accepts the word when m_valid && m_ready.
- m_data  output  N  completed word.
- m_perr  output  1  parity error flag, qualified by m_valid.
- bit_cnt  output  CNT_W  number of bits captured into the current partial word (debug).

Behaviour:
- Reset (rst=1 at a clk edge):
  - bit_cnt=0, m_valid=0, m_data=0, m_perr=0, all lane cells=0.
  - s_ready=0 during the reset cycle.
  - Reset mid-word discards the partial word and any held output word.
- Word length: W = N data bits (N+1 with the parity feature).
- Accept (acc = s_valid && s_ready && !clr):
  - Lane k (k<N) loads s_bit when acc && bit_cnt==k.
  - bit_cnt increments on acc.
- Completion: acc && bit_cnt==W-1.
  - Next cycle: m_valid=1 and m_data = lane cells, with lane 0 holding the first bit.
  - bit_cnt returns to 0 in the same edge.
  - Latency is 1 cycle from the accepting edge of the final bit.
- s_ready:
  - s_ready = !rst && !clr && !(bit_cnt==W-1 && m_valid && !m_ready).
  - Only the completing bit stalls. Earlier bits of the next word are accepted while the output is held.
- Output hold: m_data and m_perr are stable while m_valid && !m_ready.
- Pop: m_valid && m_ready clears m_valid next cycle, unless a completion occurs in the same cycle. In that case m_valid stays 1 and the new word loads, giving back-to-back words with no bubble.
- clr:
  - Sets bit_cnt=0 next cycle.
  - A bit presented with clr high is not accepted (s_ready=0); clr wins over a simultaneous completion.
  - m_valid and m_data are unaffected.
- Lane cells are not cleared at completion. Stale lanes are overwritten before the next completion, so no masking is needed.
- State encoding: FILL (m_valid=0) and HOLD (m_valid=1), orthogonal to bit_cnt.
  - FILL→HOLD on completion.
  - HOLD→FILL on pop without completion.
  - HOLD→HOLD on pop with completion, or on no pop.
- Counter never exceeds W-1. An illegal value is forced to 0 next cycle.

Optional Feature:
- Macro: STR_LANE_DESER_PARITY_EN.
- Defined:
  - W=N+1; bit index N is an even-parity bit over the N data bits.
  - m_perr = (XOR of data bits) ^ parity bit, registered together with m_data.
  - The parity bit is not visible on m_data.
- Undefined:
  - W=N; no parity cycle.
  - m_perr is tied 0; the port remains present.

Decomposition:
- Package str_lane_pkg:
  - typedef enum logic {ST_FILL, ST_HOLD} deser_state_t.
  - Constant LANE_MAX=32.
  - Function lane_cnt_w(n) returning the counter width.
- Sub-module str_lane_cell: one lane capture flop.
  - Ports: clk, rst, ld, d, q.
  - Synchronous reset to 0.
  - Instantiated N times inside the labeled generate loop gen_lane.
- Top level holds the counter, FSM, output register and parity.

Test Plan:
- N=4, m_ready=1, bits 1,0,1,1 on consecutive cycles → one cycle after the 4th accept: m_valid=1, m_data=4'b1101, bit_cnt=0.
- m_ready=0 with a word held; send bits 0,1,1,0 → first 3 accepted (bit_cnt=3), s_ready=0 on the 4th. Raise m_ready → 4'b1101 pops, 4'b0110 appears the next cycle without a bubble.
- Two words streamed continuously with m_ready=1 → m_valid is high for 2 consecutive cycles, m_data=4'hA then 4'h5, and s_ready never drops.
- clr asserted after 2 bits of a word, simultaneously with a valid bit → that bit is dropped and bit_cnt=0. The next 4 bits 1,1,1,1 produce m_data=4'hF, and the held prior word is unchanged until popped.
- rst mid-word (bit_cnt=2) with m_valid=1 → next cycle m_valid=0, m_data=0, bit_cnt=0; s_ready=0 during the reset cycle and 1 after.
- PARITY_EN, N=4:
  - Bits 1,1,0,0 with parity 0 → m_data=4'b0011, m_perr=0.
  - Bits 1,0,0,0 with parity 0 → m_data=4'b0001, m_perr=1.

Source files
------------

// File: rtl/str_lane_pkg.sv
// Shared types and helpers for the lane-serialized deserializer.
package str_lane_pkg;

   typedef enum logic {ST_FILL, ST_HOLD} deser_state_t;

   localparam int unsigned LANE_MAX = 32;

   function automatic int unsigned lane_cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/str_lane_cell.sv
// One lane capture flop: loads d when ld is high, synchronous reset to 0.
module str_lane_cell (
   input  logic clk,
   input  logic rst,
   input  logic ld,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 1'b0;
      end else if (ld) begin
         q <= d;
      end
   end

endmodule

// File: rtl/str_lane_deserializer.sv
// Serial-to-parallel receiver with one word of output buffering.
// Define STR_LANE_DESER_PARITY_EN to append an even-parity bit to each word.
module str_lane_deserializer
   import str_lane_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned CNT_W = lane_cnt_w(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             s_bit,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [N-1:0]     m_data,
   output logic             m_perr,
   output logic [CNT_W-1:0] bit_cnt
);

`ifdef STR_LANE_DESER_PARITY_EN
   localparam int unsigned W = N + 1;
`else
   localparam int unsigned W = N;
`endif
   localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

   if (N < 2 || N > LANE_MAX) begin : gen_bad_n
      $error("str_lane_deserializer: N out of range");
   end

   deser_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     lane_q, lane_ld, word;
   logic [N-1:0]     data_q, data_d;
   logic             last, acc, complete, pop;

   assign last     = (cnt_q == LAST);
   assign m_valid  = (state_q == ST_HOLD);
   // Only the completing bit has to wait for the output register to drain.
   assign s_ready  = !rst && !clr && !(last && m_valid && !m_ready);
   assign acc      = s_valid && s_ready && !clr;
   assign complete = acc && last;
   assign pop      = m_valid && m_ready;
   assign m_data   = data_q;
   assign bit_cnt  = cnt_q;

   // word is the lane contents as they will be after this edge.
   always_comb begin
      lane_ld = '0;
      word    = lane_q;
      for (int unsigned k = 0; k < N; k++) begin
         if (acc && cnt_q == CNT_W'(k)) begin
            lane_ld[k] = 1'b1;
            word[k]    = s_bit;
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : gen_lane
      str_lane_cell u_cell (
         .clk(clk),
         .rst(rst),
         .ld (lane_ld[k]),
         .d  (s_bit),
         .q  (lane_q[k])
      );
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr || cnt_q > LAST) begin
         cnt_d = '0;
      end else if (complete) begin
         cnt_d = '0;
      end else if (acc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         ST_FILL: if (complete) state_d = ST_HOLD;
         ST_HOLD: if (pop && !complete) state_d = ST_FILL;
         default: state_d = ST_FILL;
      endcase
      if (complete) begin
         data_d = word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FILL;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

`ifdef STR_LANE_DESER_PARITY_EN
   // The parity bit is the completing bit itself, so it never occupies a lane.
   logic perr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perr_q <= 1'b0;
      end else if (complete) begin
         perr_q <= (^word) ^ s_bit;
      end
   end

   assign m_perr = perr_q;
`else
   assign m_perr = 1'b0;
`endif

endmodule
